traffic_light_timed_fsm: RTL and testbench
==========================================

TRAFFIC_LIGHT_TIMED_FSM -- requirements
Module: traffic_light_timed_fsm

Interface
REQ-001 The block SHALL take parameter RED_CYCLES, default 8, as the RED phase length in clock cycles.
REQ-002 The block SHALL take parameter RED_AMBER_CYCLES, default 2, as the RED_AMBER phase length in clock cycles.
REQ-003 The block SHALL take parameter GREEN_CYCLES, default 10, as the nominal GREEN phase length in clock cycles.
REQ-004 The block SHALL take parameter AMBER_CYCLES, default 3, as the AMBER phase length in clock cycles.
REQ-005 The block SHALL take parameter MIN_GREEN_CYCLES, default 4, as the minimum GREEN dwell before a pedestrian early exit.
REQ-006 The block SHALL take parameter FLASH_CYCLES, default 4, as the half-period of the fault amber flash.
REQ-007 The block SHALL take parameter CNT_W, default 8, as the phase-counter width.
REQ-008 Port: clk  input  1  clock; all state changes on rising edge.
REQ-009 Port: rst  input  1  reset, synchronous, active-high.
REQ-010 Port: en  input  1  advance enable; low freezes phase timing.
REQ-011 Port: ped_req  input  1  pedestrian request pulse or level.
REQ-012 Port: fault  input  1  forces amber-flash mode while high.
REQ-013 Port: light  output  3  {red, amber, green} lamp drive.
REQ-014 Port: ped_walk  output  1  walk signal for pedestrians.
REQ-015 Port: ped_pending  output  1  latched, unserved pedestrian request.

Function
REQ-016 States SHALL be RED, RED_AMBER, GREEN, AMBER and FLASH.
REQ-017 light SHALL decode from the state register: RED 100, RED_AMBER 110, GREEN 001, AMBER 010, FLASH 010 or 000 (flash phase).
REQ-018 On entry to a timed phase, the counter SHALL load the phase length minus 1, then decrement each enabled cycle.
REQ-019 The phase SHALL advance when the counter is 0 and en=1, so each phase lasts exactly its parameter value in enabled cycles.
REQ-020 The normal sequence SHALL be RED->RED_AMBER->GREEN->AMBER->RED.
REQ-021 With en=0, state and counter SHALL both hold; ped_req latching and fault SHALL still act.
REQ-022 ped_req=1 on any edge SHALL set ped_pending.
REQ-023 ped_pending SHALL clear on the edge entering RED; a ped_req on that same edge SHALL leave it set.
REQ-024 In GREEN with ped_pending=1 and at least MIN_GREEN_CYCLES enabled GREEN cycles elapsed, the state SHALL move to AMBER on the next enabled edge.
REQ-025 ped_walk SHALL be 1 throughout a RED phase entered with ped_pending=1, and 0 otherwise.
REQ-026 fault=1 SHALL force FLASH on the next edge from any state, with priority over en and ped_req.
REQ-027 In FLASH, a flash counter SHALL toggle the amber lamp every FLASH_CYCLES cycles, starting lit, regardless of en.
REQ-028 While fault remains high the state SHALL stay FLASH.
REQ-029 The first edge with fault=0 in FLASH SHALL enter RED with a full RED_CYCLES load.
REQ-030 The illegal state encodings SHALL recover to RED on the next edge.
REQ-031 If any phase parameter is 0 or exceeds 2^CNT_W, the design SHALL flag it at elaboration.
REQ-032 If MIN_GREEN_CYCLES exceeds GREEN_CYCLES, the design SHALL clamp it to GREEN_CYCLES.

Reset
REQ-033 When rst=1 at an edge: state SHALL be RED, counter RED_CYCLES-1, ped_pending 0, flash counter 0.
REQ-034 Outputs after reset SHALL be light=100, ped_walk=0.
REQ-035 rst SHALL override fault, en and ped_req, including mid-phase and in FLASH.

Structure
REQ-036 The state enumeration and lamp encodings SHALL live in a shared package, traffic_light_pkg.
REQ-037 One sub-module, phase_timer (load/decrement/zero-flag down-counter, CNT_W wide), SHALL be instantiated for the phase timing.
REQ-038 The flash timing SHALL reuse a second phase_timer instance.

Verification
Benches use RED=4, RED_AMBER=2, GREEN=6, AMBER=2, MIN_GREEN=2, FLASH=3.
REQ-039 Reset release, en=1, no requests -> light 100 x4, 110 x2, 001 x6, 010 x2, then 100; this repeats indefinitely.
REQ-040 ped_req pulse in GREEN cycle 0 -> GREEN lasts 2 cycles; AMBER x2; RED with ped_walk=1 for 4 cycles; ped_pending clears on RED entry.
REQ-041 ped_req during RED_AMBER -> GREEN lasts MIN_GREEN=2; ped_req on the RED-entry edge -> ped_pending stays 1.
REQ-042 en=0 for 5 cycles mid-GREEN -> light holds 001; the remaining GREEN count resumes unchanged.
REQ-043 fault=1 in AMBER -> light 010 x3, 000 x3, repeating; fault=0 -> RED for 4 cycles, then the normal sequence.
REQ-044 rst=1 mid-FLASH with fault=1 and ped_pending=1 -> next cycle light=100, ped_pending=0, ped_walk=0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared state enumeration, lamp encodings and parameter range helper
// for the timed traffic-light controller.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ST_RED       = 3'd0,
        ST_RED_AMBER = 3'd1,
        ST_GREEN     = 3'd2,
        ST_AMBER     = 3'd3,
        ST_FLASH     = 3'd4
    } state_t;

    // Lamp drive bit order is {red, amber, green}.
    localparam logic [2:0] LAMP_RED       = 3'b100;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
    localparam logic [2:0] LAMP_GREEN     = 3'b001;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;
    localparam logic [2:0] LAMP_OFF       = 3'b000;

    function automatic bit phase_len_ok(input int len, input int cnt_w);
        return (len >= 1) && (longint'(len) <= (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/traffic_light_timed_fsm_phase_timer.sv
// Loadable down-counter with zero flag; used for phase timing and flash timing.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_timed_fsm.sv
// Timed traffic-light controller: RED/RED_AMBER/GREEN/AMBER cycle with
// pedestrian early-exit from GREEN and a fault-driven amber flash mode.
module traffic_light_timed_fsm
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES       = 8,
    parameter int RED_AMBER_CYCLES = 2,
    parameter int GREEN_CYCLES     = 10,
    parameter int AMBER_CYCLES     = 3,
    parameter int MIN_GREEN_CYCLES = 4,
    parameter int FLASH_CYCLES     = 4,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ped_req,
    input  logic       fault,
    output logic [2:0] light,
    output logic       ped_walk,
    output logic       ped_pending
);

    if (!phase_len_ok(RED_CYCLES, CNT_W)) begin : g_bad_red
        $error("RED_CYCLES must be in 1..2**CNT_W");
    end
    if (!phase_len_ok(RED_AMBER_CYCLES, CNT_W)) begin : g_bad_red_amber
        $error("RED_AMBER_CYCLES must be in 1..2**CNT_W");
    end
    if (!phase_len_ok(GREEN_CYCLES, CNT_W)) begin : g_bad_green
        $error("GREEN_CYCLES must be in 1..2**CNT_W");
    end
    if (!phase_len_ok(AMBER_CYCLES, CNT_W)) begin : g_bad_amber
        $error("AMBER_CYCLES must be in 1..2**CNT_W");
    end
    if (!phase_len_ok(FLASH_CYCLES, CNT_W)) begin : g_bad_flash
        $error("FLASH_CYCLES must be in 1..2**CNT_W");
    end

    localparam int MIN_GREEN_EFF = (MIN_GREEN_CYCLES > GREEN_CYCLES) ? GREEN_CYCLES :
                                   (MIN_GREEN_CYCLES < 1) ? 1 : MIN_GREEN_CYCLES;
    // GREEN counter value at which MIN_GREEN_EFF cycles have been served.
    localparam logic [CNT_W-1:0] GREEN_EXIT_MAX = CNT_W'(GREEN_CYCLES - MIN_GREEN_EFF);

    function automatic logic [CNT_W-1:0] phase_len_m1(input state_t s);
        case (s)
            ST_RED:       return CNT_W'(RED_CYCLES - 1);
            ST_RED_AMBER: return CNT_W'(RED_AMBER_CYCLES - 1);
            ST_GREEN:     return CNT_W'(GREEN_CYCLES - 1);
            ST_AMBER:     return CNT_W'(AMBER_CYCLES - 1);
            default:      return '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_cnt;
    logic             phase_zero, phase_load, phase_dec;
    logic [CNT_W-1:0] flash_cnt_unused;
    logic             flash_zero, flash_load, flash_dec;
    logic             flash_on_q, ped_pending_q, walk_q;
    logic             entering_red;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RED;
        else     state_q <= state_d;
    end

    // NOTE: defaulting state_d before the case keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FLASH;
        end else begin
            case (state_q)
                ST_RED:       if (en && phase_zero) state_d = ST_RED_AMBER;
                ST_RED_AMBER: if (en && phase_zero) state_d = ST_GREEN;
                ST_GREEN:     if (en && (phase_zero || (ped_pending_q && phase_cnt <= GREEN_EXIT_MAX)))
                                  state_d = ST_AMBER;
                ST_AMBER:     if (en && phase_zero) state_d = ST_RED;
                ST_FLASH:     state_d = ST_RED;
                default:      state_d = ST_RED;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_RED:       light = LAMP_RED;
            ST_RED_AMBER: light = LAMP_RED_AMBER;
            ST_GREEN:     light = LAMP_GREEN;
            ST_AMBER:     light = LAMP_AMBER;
            ST_FLASH:     light = flash_on_q ? LAMP_AMBER : LAMP_OFF;
            default:      light = LAMP_RED;
        endcase
    end

    assign entering_red = (state_d == ST_RED) && (state_q != ST_RED);
    assign phase_load   = (state_d != state_q);
    assign phase_dec    = en && (state_q != ST_FLASH);
    assign flash_load   = (state_d == ST_FLASH) && ((state_q != ST_FLASH) || flash_zero);
    assign flash_dec    = (state_d == ST_FLASH) && (state_q == ST_FLASH);

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(RED_CYCLES - 1))) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_len_m1(state_d)),
        .dec      (phase_dec),
        .count    (phase_cnt),
        .zero     (phase_zero)
    );

    phase_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_flash_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (flash_load),
        .load_val (CNT_W'(FLASH_CYCLES - 1)),
        .dec      (flash_dec),
        .count    (flash_cnt_unused),
        .zero     (flash_zero)
    );

    // A request on the RED-entry edge wins over the clear, so it is served next GREEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            flash_on_q    <= 1'b0;
        end else begin
            if (ped_req)           ped_pending_q <= 1'b1;
            else if (entering_red) ped_pending_q <= 1'b0;

            if (entering_red)           walk_q <= ped_pending_q;
            else if (state_d != ST_RED) walk_q <= 1'b0;

            if (state_d == ST_FLASH) begin
                if (state_q != ST_FLASH) flash_on_q <= 1'b1;
                else if (flash_zero)     flash_on_q <= ~flash_on_q;
            end
        end
    end

    assign ped_walk    = walk_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_light_timed_fsm.sv
// Scoreboard bench: a phase-level reference model predicts lamps and pedestrian
// outputs per edge; a negedge monitor compares them against the DUT.
module tb_traffic_light_timed_fsm;

    localparam int RED  = 4;
    localparam int RA   = 2;
    localparam int GRN  = 6;
    localparam int AMB  = 2;
    localparam int MING = 2;
    localparam int FL   = 3;

    logic       clk = 1'b0;
    logic       rst, en, ped_req, fault;
    logic [2:0] light;
    logic       ped_walk, ped_pending;

    always #5 clk = ~clk;

    traffic_light_timed_fsm #(
        .RED_CYCLES       (RED),
        .RED_AMBER_CYCLES (RA),
        .GREEN_CYCLES     (GRN),
        .AMBER_CYCLES     (AMB),
        .MIN_GREEN_CYCLES (MING),
        .FLASH_CYCLES     (FL),
        .CNT_W            (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ped_req     (ped_req),
        .fault       (fault),
        .light       (light),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending)
    );

    typedef struct packed {
        logic [2:0] light;
        logic       walk;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: phase index into the normal sequence plus cycles left.
    int lens[4]          = '{RED, RA, GRN, AMB};
    logic [2:0] lamps[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int m_phase = 0, m_left = RED, m_flash_t = 0;
    bit m_in_flash = 0, m_pend = 0, m_walk = 0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic p, input logic f);
        bit old_pend, enter_red;
        old_pend  = m_pend;
        enter_red = 0;
        if (r) begin
            m_phase = 0; m_left = RED; m_in_flash = 0; m_flash_t = 0;
            m_pend = 0; m_walk = 0;
            return;
        end
        if (f) begin
            if (m_in_flash) m_flash_t++;
            else begin m_in_flash = 1; m_flash_t = 0; end
            m_walk = 0;
        end else if (m_in_flash) begin
            m_in_flash = 0;
            enter_red  = 1;
        end else if (e) begin
            if (m_left == 1 || (m_phase == 2 && old_pend && (GRN - m_left + 1) >= MING)) begin
                m_phase = (m_phase + 1) % 4;
                if (m_phase == 0) enter_red = 1;
                else m_walk = 0;
                m_left = lens[m_phase];
            end else begin
                m_left--;
            end
        end
        if (enter_red) begin
            m_phase = 0; m_left = RED; m_walk = old_pend; m_pend = 0;
        end
        if (p) m_pend = 1;
    endtask

    function automatic exp_t model_out();
        exp_t o;
        if (m_in_flash) o.light = (((m_flash_t / FL) % 2) == 0) ? 3'b010 : 3'b000;
        else            o.light = lamps[m_phase];
        o.walk = m_walk;
        o.pend = m_pend;
        return o;
    endfunction

    task automatic step(input logic r, input logic e, input logic p, input logic f);
        rst = r; en = e; ped_req = p; fault = f;
        @(posedge clk);
        model_step(r, e, p, f);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic advance_to(input int ph, input int left);
        int guard;
        guard = 0;
        while (guard < 100 && !(!m_in_flash && m_phase == ph && m_left == left)) begin
            step(0, 1, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL advance_to: phase %0d left %0d not reached, at phase %0d left %0d", ph, left, m_phase, m_left);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("light",       light,               e.light);
            check("ped_walk",    {2'b00, ped_walk},    {2'b00, e.walk});
            check("ped_pending", {2'b00, ped_pending}, {2'b00, e.pend});
        end
    end

    initial begin
        int fault_left;
        rst = 1; en = 0; ped_req = 0; fault = 0;
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);

        // Free-running normal sequence.
        repeat (40) step(0, 1, 0, 0);

        // Request in GREEN cycle 0 shortens GREEN to the minimum and walks next RED.
        advance_to(2, GRN);
        step(0, 1, 1, 0);
        repeat (14) step(0, 1, 0, 0);

        // Request in RED_AMBER, then a request on the RED-entry edge.
        advance_to(1, RA);
        step(0, 1, 1, 0);
        advance_to(3, 1);
        step(0, 1, 1, 0);
        repeat (20) step(0, 1, 0, 0);

        // Freeze mid-GREEN.
        advance_to(2, 4);
        repeat (5) step(0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0);

        // Fault in AMBER, then recovery.
        advance_to(3, AMB);
        repeat (14) step(0, 1, 0, 1);
        repeat (20) step(0, 1, 0, 0);

        // Reset during FLASH with a pending request.
        repeat (4) step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        repeat (6) step(0, 1, 0, 0);

        // Randomized traffic with fault bursts and rare resets.
        fault_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, e, p, f;
            r = ($urandom_range(0, 499) == 0);
            e = ($urandom_range(0, 99) < 80);
            p = ($urandom_range(0, 99) < 8);
            if (fault_left > 0) begin
                f = 1; fault_left--;
            end else if ($urandom_range(0, 149) == 0) begin
                f = 1; fault_left = $urandom_range(1, 12);
            end else begin
                f = 0;
            end
            step(r, e, p, f);
        end

        // Let the monitor drain the scoreboard within a bounded window.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
